// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcode
// classes, function codes and the fixed ALU operations.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_IEXEC  = 4'd3,
        S_REXEC  = 4'd4,
        S_BRANCH = 4'd5,
        S_JUMP   = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWR  = 4'd8,
        S_ALUWB  = 4'd9,
        S_MEMWB  = 4'd10,
        S_LI     = 4'd11,
        S_LUI    = 4'd12,
        S_IMMWB  = 4'd13,
        S_HALT   = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [1:0] CLS_J = 2'b00;
    localparam logic [1:0] CLS_R = 2'b01;
    localparam logic [1:0] CLS_B = 2'b10;
    localparam logic [1:0] CLS_I = 2'b11;

    localparam logic [3:0] FN_LI   = 4'b1001;
    localparam logic [3:0] FN_LUI  = 4'b1010;
    localparam logic [3:0] FN_LWI  = 4'b1011;
    localparam logic [3:0] FN_SWI  = 4'b1100;
    localparam logic [3:0] FN_LW   = 4'b1101;
    localparam logic [3:0] FN_SW   = 4'b1110;
    localparam logic [3:0] FN_BAD  = 4'b1111;
    localparam logic [3:0] FN_BMAX = 4'b0011;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_HALT = 6'b001111;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0000;

    function automatic logic is_store(input logic [3:0] fn);
        return (fn == FN_SWI) || (fn == FN_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Opcode to next-state map for the DECODE and MEMADR states.
// Purely combinational; the FSM register lives in the top.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     decode_next,
    output state_t     memadr_next
);

    logic [1:0] cls;
    logic [3:0] fn;

    assign cls = opcode[5:4];
    assign fn  = opcode[3:0];

    always_comb begin
        decode_next = S_IEXEC;
        unique case (cls)
            CLS_J: begin
                if (opcode == OP_NOP)
                    decode_next = S_FETCH;
                else if (opcode == OP_HALT)
                    decode_next = S_HALT;
                else
                    decode_next = S_JUMP;
            end
            CLS_R: decode_next = S_REXEC;
            CLS_B: begin
                if (fn <= FN_BMAX)
                    decode_next = S_BRANCH;
                else
                    decode_next = S_TRAP;
            end
            CLS_I: begin
                unique case (fn)
                    FN_LI:  decode_next = S_LI;
                    FN_LUI: decode_next = S_LUI;
                    FN_LWI, FN_SWI,
                    FN_LW, FN_SW:
                            decode_next = S_MEMADR;
                    FN_BAD: decode_next = S_TRAP;
                    default: decode_next = S_IEXEC;
                endcase
            end
        endcase
    end

    assign memadr_next = is_store(fn) ? S_MEMWR : S_MEMRD;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle Moore controller: state register plus per-state
// datapath strobes derived from the state and the IR opcode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int WAIT_EN = 1,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic [3:0]         state,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               lui,
    output logic               swb,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         branch_type,
    output logic               halted,
    output logic               illegal
);

    state_t     st;
    state_t     dec_next;
    state_t     mem_next;
    logic [5:0] opcode;
    logic [3:0] fn;
    logic       ready;
    logic       unused_bits;

    assign opcode = instr[INSTR_W-1 -: 6];
    assign fn     = opcode[3:0];
    assign ready  = (WAIT_EN == 0) ? 1'b1 : mem_ready;
    assign state  = st;

    assign unused_bits = ^{instr[INSTR_W-7:0], mem_ready};

    multicycle_ctrl_decode u_decode (
        .opcode      (opcode),
        .decode_next (dec_next),
        .memadr_next (mem_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_FETCH;
        end else begin
            unique case (st)
                S_FETCH:  if (ready) st <= S_DECODE;
                S_DECODE: st <= dec_next;
                S_MEMADR: st <= mem_next;
                S_IEXEC,
                S_REXEC:  st <= S_ALUWB;
                S_MEMRD:  if (ready) st <= S_MEMWB;
                S_MEMWR:  if (ready) st <= S_FETCH;
                S_LI,
                S_LUI:    st <= S_IMMWB;
                S_BRANCH, S_JUMP, S_ALUWB,
                S_MEMWB, S_IMMWB:
                          st <= S_FETCH;
                S_HALT,
                S_TRAP:   st <= st;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        lui         = 1'b0;
        swb         = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        alu_op      = '0;
        branch_type = 3'd0;
        halted      = 1'b0;
        illegal     = 1'b0;
        unique case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_W'(ALU_ADD);
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(ALU_PASS);
                swb       = (dec_next == S_BRANCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_W'(ALU_ADD);
                swb       = (mem_next == S_MEMWR);
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_W'(fn);
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(fn);
            end
            S_BRANCH: begin
                pc_write    = 1'b1;
                swb         = 1'b1;
                branch_type = {1'b0, fn[1:0]} + 3'd1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_MEMRD: mem_read = 1'b1;
            S_MEMWR: begin
                mem_write = 1'b1;
                swb       = 1'b1;
            end
            S_ALUWB: reg_write = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_IMMWB: reg_write = 1'b1;
            S_LI: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(fn);
            end
            S_LUI: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(fn);
                lui       = 1'b1;
            end
            S_HALT: halted = 1'b1;
            S_TRAP: illegal = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state-path model with
// per-cycle output comparison plus directed literal checks.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       lui;
        logic       swb;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic [2:0] branch_type;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] instr2 = '0;

    logic [3:0] state, state2;
    logic pc_write, ir_write, mem_read, mem_write, mem_to_reg;
    logic reg_write, alu_src_a, lui, swb, halted, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic [2:0] branch_type;
    logic pc_write2, ir_write2, mem_read2, mem_write2, mem_to_reg2;
    logic reg_write2, alu_src_a2, lui2, swb2, halted2, illegal2;
    logic [1:0] alu_src_b2, pc_source2;
    logic [3:0] alu_op2;
    logic [2:0] branch_type2;

    obs_t obs, obs2;

    assign obs = {state, pc_write, ir_write, mem_read, mem_write,
                  mem_to_reg, reg_write, alu_src_a, lui, swb,
                  alu_src_b, pc_source, alu_op, branch_type,
                  halted, illegal};
    assign obs2 = {state2, pc_write2, ir_write2, mem_read2, mem_write2,
                   mem_to_reg2, reg_write2, alu_src_a2, lui2, swb2,
                   alu_src_b2, pc_source2, alu_op2, branch_type2,
                   halted2, illegal2};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .lui(lui), .swb(swb),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
        .branch_type(branch_type), .halted(halted), .illegal(illegal)
    );

    multicycle_ctrl #(.WAIT_EN(0)) dut_nowait (
        .clk(clk), .reset(reset), .instr(instr2), .mem_ready(1'b0),
        .state(state2), .pc_write(pc_write2), .ir_write(ir_write2),
        .mem_read(mem_read2), .mem_write(mem_write2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2),
        .alu_src_a(alu_src_a2), .lui(lui2), .swb(swb2),
        .alu_src_b(alu_src_b2), .pc_source(pc_source2), .alu_op(alu_op2),
        .branch_type(branch_type2), .halted(halted2), .illegal(illegal2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit model_on = 0;
    bit rec = 0;
    int exp_st = 0;
    int path[$];
    obs_t tr[$];
    obs_t tr2[$];

    // Remaining states an instruction walks through after DECODE.
    function automatic void plan(input logic [5:0] op);
        int c;
        int f;
        c = int'(op[5:4]);
        f = int'(op[3:0]);
        path.delete();
        if (op == 6'd0) path = {};
        else if (op == 6'h0F) path = '{14};
        else if (c == 0) path = '{6};
        else if (c == 1) path = '{4, 9};
        else if (c == 2) path = (f <= 3) ? '{5} : '{15};
        else if (f == 9) path = '{11, 13};
        else if (f == 10) path = '{12, 13};
        else if (f == 11 || f == 13) path = '{2, 7, 10};
        else if (f == 12 || f == 14) path = '{2, 8};
        else if (f == 15) path = '{15};
        else path = '{3, 9};
    endfunction

    function automatic obs_t expect_of(input int s, input logic [5:0] op,
                                       input logic rdy);
        obs_t e;
        logic [3:0] f;
        e = '0;
        f = op[3:0];
        e.st = 4'(s);
        case (s)
            0: begin
                e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 4'b0010;
                e.ir_write = rdy; e.pc_write = rdy;
            end
            1: begin
                e.alu_src_b = 2'b11;
                e.swb = (op[5:4] == 2'b10) && (f <= 4'd3);
            end
            2: begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 4'b0010;
                e.swb = (f == 4'd12) || (f == 4'd14);
            end
            3: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = f; end
            4: begin e.alu_src_a = 1; e.alu_op = f; end
            5: begin
                e.pc_write = 1; e.swb = 1;
                e.branch_type = 3'(int'(f) + 1);
            end
            6: begin e.pc_write = 1; e.pc_source = 2'b10; end
            7: e.mem_read = 1;
            8: begin e.mem_write = 1; e.swb = 1; end
            9: e.reg_write = 1;
            10: begin e.reg_write = 1; e.mem_to_reg = 1; end
            11: begin e.alu_src_b = 2'b11; e.alu_op = f; end
            12: begin e.alu_src_b = 2'b11; e.alu_op = f; e.lui = 1; end
            13: e.reg_write = 1;
            14: e.halted = 1;
            15: e.illegal = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int next_in_path();
        if (path.size() > 0) return path.pop_front();
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_st = 0;
            path.delete();
            model_on = 1;
        end else if (model_on) begin
            case (exp_st)
                0: if (mem_ready) exp_st = 1;
                1: begin plan(instr[31:26]); exp_st = next_in_path(); end
                7, 8: if (mem_ready) exp_st = next_in_path();
                14, 15: exp_st = exp_st;
                default: exp_st = next_in_path();
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            obs_t e;
            e = expect_of(exp_st, instr[31:26], mem_ready);
            checks++;
            if (obs === e) passes++;
            else $display("FAIL model t=%0t got %h want %h (st %0d vs %0d)",
                          $time, obs, e, obs.st, e.st);
        end
        if (rec) begin
            tr.push_back(obs);
            tr2.push_back(obs2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s got %0h want %0h", name, act, want);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h1555555};
    endfunction

    task automatic hold(input logic [31:0] i, input logic r,
                        input logic rs, input int n);
        repeat (n) begin
            instr = i;
            mem_ready = r;
            reset = rs;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_rec();
        tr.delete();
        tr2.delete();
        rec = 1;
    endtask

    // One instruction from FETCH back to FETCH; returns its cycle count.
    task automatic run_op(input logic [5:0] op, input logic [7:0] pat,
                          output int n);
        bit left;
        left = 0;
        n = 0;
        instr = mk(op);
        reset = 0;
        do begin
            mem_ready = pat[n % 8];
            @(posedge clk);
            #1;
            n++;
            if (exp_st != 0) left = 1;
        end while (!(left && exp_st == 0) && n < 40);
        if (n >= 40) chk("run_op_timeout", 32'(n), 32'd0);
    endtask

    logic [5:0] lat_op[12] = '{6'b010010, 6'b110000, 6'b111001, 6'b111010,
                               6'b111101, 6'b111011, 6'b111110, 6'b111100,
                               6'b100000, 6'b100011, 6'b000001, 6'b000000};
    int lat_exp[12] = '{4, 4, 4, 4, 5, 5, 4, 4, 3, 3, 3, 2};
    logic [7:0] pats[3] = '{8'hA6, 8'h3C, 8'h5A};

    initial begin
        int n;
        int c1;
        int c2;
        logic [3:0] bits;

        hold(32'd0, 1, 1, 2);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);

        start_rec();
        hold(mk(6'b010010), 1, 0, 4);
        rec = 0;
        chk("add_states", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, 32'h0149);
        chk("add_aluop", 32'(tr[2].alu_op), 32'h2);
        bits = {tr[0].reg_write, tr[1].reg_write, tr[2].reg_write,
                tr[3].reg_write};
        chk("add_regwrite", 32'(bits), 32'h1);
        chk("add_back_fetch", 32'(state), 32'd0);

        start_rec();
        hold(mk(6'b111101), 1, 0, 3);
        hold(mk(6'b111101), 0, 0, 3);
        hold(mk(6'b111101), 1, 0, 2);
        rec = 0;
        c1 = 0;
        c2 = 0;
        foreach (tr[k]) begin
            if (tr[k].st == 4'd7) c1++;
            if (tr[k].st == 4'd7 && tr[k].mem_read) c2++;
        end
        chk("lw_memrd_cycles", 32'(c1), 32'd4);
        chk("lw_memread_held", 32'(c2), 32'd4);
        chk("lw_memwb", {tr[7].st, 3'b0, tr[7].mem_to_reg}, 32'hA1);

        start_rec();
        hold(32'd0, 0, 0, 2);
        hold(32'd0, 1, 0, 2);
        rec = 0;
        c1 = 0;
        c2 = 0;
        foreach (tr[k]) begin
            c1 += int'(tr[k].pc_write);
            c2 += int'(tr[k].ir_write);
        end
        chk("stall_states", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, 32'h0001);
        chk("stall_pcwrite", 32'(c1), 32'd1);
        chk("stall_irwrite", 32'(c2), 32'd1);

        start_rec();
        hold(mk(6'b100010), 1, 0, 3);
        rec = 0;
        chk("blt_state", 32'(tr[2].st), 32'd5);
        chk("blt_type", 32'(tr[2].branch_type), 32'd3);
        chk("blt_pcwrite", 32'(tr[2].pc_write), 32'd1);

        foreach (lat_op[k]) begin
            run_op(lat_op[k], 8'hFF, n);
            chk($sformatf("latency_%b", lat_op[k]), 32'(n), 32'(lat_exp[k]));
        end
        foreach (pats[p])
            foreach (lat_op[k]) run_op(lat_op[k], pats[p], n);

        hold(mk(6'b100101), 1, 0, 2);
        start_rec();
        hold(mk(6'b100101), 1, 0, 3);
        hold(mk(6'b100101), 0, 0, 3);
        rec = 0;
        c1 = 0;
        foreach (tr[k]) if (tr[k].st == 4'd15 && tr[k].illegal) c1++;
        chk("trap_sticky", 32'(c1), 32'd6);
        hold(32'd0, 1, 1, 1);
        chk("trap_reset_state", 32'(state), 32'd0);
        chk("trap_reset_illegal", 32'(illegal), 32'd0);
        hold(mk(6'b111111), 1, 0, 2);
        chk("trap_cls3_fn15", 32'(state), 32'd15);
        hold(32'd0, 1, 1, 1);

        hold(mk(6'b001111), 1, 0, 2);
        start_rec();
        hold(mk(6'b001111), 1, 0, 6);
        hold(mk(6'b001111), 0, 0, 6);
        rec = 0;
        c1 = 0;
        foreach (tr[k]) if (tr[k].halted) c1++;
        chk("halt_held", 32'(c1), 32'd12);
        hold(32'd0, 1, 1, 1);
        chk("halt_reset_state", 32'(state), 32'd0);
        chk("halt_reset_halted", 32'(halted), 32'd0);

        hold(mk(6'b111101), 1, 0, 3);
        hold(mk(6'b111101), 0, 0, 2);
        chk("midstall_memrd", 32'(state), 32'd7);
        hold(mk(6'b111101), 0, 1, 1);
        chk("midstall_reset", 32'(state), 32'd0);

        instr2 = mk(6'b111110);
        hold(32'd0, 1, 1, 1);
        start_rec();
        hold(32'd0, 1, 0, 4);
        rec = 0;
        c1 = 0;
        foreach (tr2[k]) c1 += int'(tr2[k].mem_write);
        chk("nowait_states", {tr2[0].st, tr2[1].st, tr2[2].st, tr2[3].st},
            32'h0128);
        chk("nowait_memwrite", 32'(c1), 32'd1);
        chk("nowait_irwrite", 32'(tr2[0].ir_write), 32'd1);
        chk("nowait_done", 32'(state2), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
